// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - mode encodings and width helper shared by stream_mux_n and its arbiter
package stream_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Index width for n channels; never below 1 so a 2-channel mux still has a select bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - combinational round-robin pick, first requester after ptr wins
module stream_mux_rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int  N_CH  = 4,
   localparam int SEL_W = clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] grant,
   output logic             grant_valid
);

   logic [2*N_CH-1:0] dbl;
   logic [N_CH-1:0]   rot;
   int                sh;
   int                off;
   int                pos;

   // Rotate so bit 0 of rot is channel ptr+1, then take the lowest set bit.
   always_comb begin
      sh          = int'(ptr) + 1;
      dbl         = {req, req} >> sh;
      rot         = dbl[N_CH-1:0];
      off         = 0;
      grant_valid = 1'b0;
      for (int j = N_CH - 1; j >= 0; j--) begin
         if (rot[j]) begin
            off         = j;
            grant_valid = 1'b1;
         end
      end
      pos = sh + off;
      if (pos >= N_CH) pos = pos - N_CH;
      grant = SEL_W'(pos);
   end

endmodule

// File: rtl/stream_mux_n.sv
// rtl/stream_mux_n.sv - N-channel packet-locked stream selector, registered output; STREAM_MUX_SKID_EN adds a skid entry
module stream_mux_n
   import stream_mux_pkg::*;
#(
   parameter int  DATA_W = 27,
   parameter int  N_CH   = 4,
   localparam int SEL_W  = clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_CH*DATA_W-1:0] in_data,
   input  logic [N_CH-1:0]        in_valid,
   input  logic [N_CH-1:0]        in_last,
   output logic [N_CH-1:0]        in_ready,
   input  logic                   mode,
   input  logic [SEL_W-1:0]       sel,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_last,
   output logic [SEL_W-1:0]       out_src,
   output logic                   out_valid,
   input  logic                   out_ready
);

   logic              lock;
   logic              lock_mode;
   logic [SEL_W-1:0]  lock_ch;
   logic [SEL_W-1:0]  rr_ptr;
   logic [SEL_W-1:0]  rr_grant;
   logic              rr_valid;
   logic [SEL_W-1:0]  grant;
   logic              granted;
   logic              accept;
   logic              xfer;
   logic              eff_mode;
   logic [DATA_W-1:0] beat_data;
   logic              beat_last;

   stream_mux_rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req         (in_valid),
      .ptr         (rr_ptr),
      .grant       (rr_grant),
      .grant_valid (rr_valid)
   );

   // Mode seen at packet start stays in force until the closing beat.
   assign eff_mode = lock ? lock_mode : mode;

   always_comb begin
      grant   = '0;
      granted = 1'b0;
      if (lock) begin
         grant   = lock_ch;
         granted = 1'b1;
      end else if (mode == MODE_RR) begin
         grant   = rr_grant;
         granted = rr_valid;
      end else if (int'(sel) < N_CH) begin
         grant   = sel;
         granted = in_valid[sel];
      end
   end

   always_comb begin
      beat_data = '0;
      beat_last = 1'b0;
      in_ready  = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (granted && grant == SEL_W'(i)) begin
            beat_data   = in_data[i*DATA_W +: DATA_W];
            beat_last   = in_last[i];
            in_ready[i] = accept;
         end
      end
   end

   assign xfer = |(in_valid & in_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock      <= 1'b0;
         lock_mode <= MODE_FIXED;
         lock_ch   <= '0;
         rr_ptr    <= SEL_W'(N_CH - 1);
      end else if (xfer) begin
         if (beat_last) begin
            lock <= 1'b0;
            if (eff_mode == MODE_RR) rr_ptr <= grant;
         end else begin
            lock      <= 1'b1;
            lock_ch   <= grant;
            lock_mode <= eff_mode;
         end
      end
   end

`ifdef STREAM_MUX_SKID_EN
   logic              skid_full;
   logic [DATA_W-1:0] skid_data;
   logic              skid_last;
   logic [SEL_W-1:0]  skid_src;

   // Readiness comes only from local state, so out_ready never reaches in_ready.
   assign accept = !skid_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= '0;
         skid_full <= 1'b0;
         skid_data <= '0;
         skid_last <= 1'b0;
         skid_src  <= '0;
      end else if (xfer) begin
         if (out_valid && !out_ready) begin
            skid_full <= 1'b1;
            skid_data <= beat_data;
            skid_last <= beat_last;
            skid_src  <= grant;
         end else begin
            out_valid <= 1'b1;
            out_data  <= beat_data;
            out_last  <= beat_last;
            out_src   <= grant;
         end
      end else if (out_ready || !out_valid) begin
         if (skid_full) begin
            out_valid <= 1'b1;
            out_data  <= skid_data;
            out_last  <= skid_last;
            out_src   <= skid_src;
            skid_full <= 1'b0;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end
`else
   assign accept = out_ready || !out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= beat_data;
         out_last  <= beat_last;
         out_src   <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// tb/tb_stream_mux_n.sv - scoreboard bench for stream_mux_n, builds with or without STREAM_MUX_SKID_EN
module tb_stream_mux_n;
   localparam int W  = 27;
   localparam int N  = 4;
   localparam int SW = 2;
`ifdef STREAM_MUX_SKID_EN
   localparam int SKID = 1;
`else
   localparam int SKID = 0;
`endif

   typedef struct packed {
      logic [SW-1:0] src;
      logic          last;
      logic [W-1:0]  data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]  in_valid = '0;
   logic [N-1:0]  in_last = '0;
   logic [N-1:0]  in_ready;
   logic          mode = 1'b0;
   logic [SW-1:0] sel = '0;
   logic [W-1:0]  out_data;
   logic          out_last;
   logic [SW-1:0] out_src;
   logic          out_valid;
   logic          out_ready = 1'b1;

   logic [3*W-1:0] d3_data = {27'h333, 27'h222, 27'h111};
   logic [2:0]    d3_valid = 3'b111;
   logic [2:0]    d3_last = 3'b111;
   logic [2:0]    d3_ready;
   logic          d3_mode = 1'b0;
   logic [1:0]    d3_sel = 2'd3;
   logic [W-1:0]  d3_out_data;
   logic          d3_out_last;
   logic [1:0]    d3_out_src;
   logic          d3_out_valid;
   logic          d3_out_ready = 1'b1;

   always #5 clk = ~clk;

   stream_mux_n #(.DATA_W(W), .N_CH(N)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data), .out_last(out_last),
      .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
   );

   stream_mux_n #(.DATA_W(W), .N_CH(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(d3_data), .in_valid(d3_valid), .in_last(d3_last),
      .in_ready(d3_ready), .mode(d3_mode), .sel(d3_sel), .out_data(d3_out_data), .out_last(d3_out_last),
      .out_src(d3_out_src), .out_valid(d3_out_valid), .out_ready(d3_out_ready)
   );

   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   first_fire = -1;
   int   first_out = -1;
   int   last_out = -1;
   exp_t expq[$];
   logic [W-1:0] sd[N][16];
   logic sl[N][16];
   int   nb[N];
   int   hd[N];
   bit   gap[N];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic present();
      for (int i = 0; i < N; i++) begin
         if (hd[i] < nb[i]) begin
            in_valid[i]       = !gap[i];
            in_data[i*W +: W] = sd[i][hd[i]];
            in_last[i]        = sl[i][hd[i]];
         end else begin
            in_valid[i]       = 1'b0;
            in_data[i*W +: W] = '0;
            in_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic load(input int ch, input logic [W-1:0] d, input logic l);
      sd[ch][nb[ch]] = d;
      sl[ch][nb[ch]] = l;
      nb[ch]++;
   endtask

   task automatic push_exp(input logic [SW-1:0] s, input logic l, input logic [W-1:0] d);
      exp_t e;
      e.src  = s;
      e.last = l;
      e.data = d;
      expq.push_back(e);
   endtask

   task automatic step();
      logic [N-1:0] fire;
      exp_t e;
      @(negedge clk);
      cyc++;
      fire = rst_n ? (in_valid & in_ready) : '0;
      if (fire != '0 && first_fire < 0) first_fire = cyc;
      if (out_valid && out_ready) begin
         check("sb_entry", 64'(expq.size() != 0), 64'd1);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_src", 64'(out_src), 64'(e.src));
            check("out_last", 64'(out_last), 64'(e.last));
         end
         if (first_out < 0) first_out = cyc;
         last_out = cyc;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (fire[i]) hd[i]++;
      present();
   endtask

   task automatic wait_head(input string tag, input int ch, input int target);
      int k = 0;
      while (hd[ch] < target && k < 50) begin
         step();
         k++;
      end
      check(tag, 64'(hd[ch] >= target), 64'd1);
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (expq.size() != 0 && k < 100) begin
         step();
         k++;
      end
      check(tag, 64'(expq.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      expq.delete();
      for (int i = 0; i < N; i++) begin
         nb[i]  = 0;
         hd[i]  = 0;
         gap[i] = 1'b0;
      end
      present();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      first_fire = -1;
      first_out  = -1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int h0;
      for (int i = 0; i < N; i++) begin
         nb[i] = 0; hd[i] = 0; gap[i] = 1'b0;
      end
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_out_src", 64'(out_src), 64'd0);

      // Illegal select on a 3-channel instance, then a legal one.
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("ill_ready", 64'(d3_ready), 64'd0);
         check("ill_out_valid", 64'(d3_out_valid), 64'd0);
      end
      @(posedge clk); #1; d3_sel = 2'd1; #1;
      check("ill_recover_ready", 64'(d3_ready), 64'b010);
      @(posedge clk); #1;
      check("ill_recover_valid", 64'(d3_out_valid), 64'd1);
      check("ill_recover_src", 64'(d3_out_src), 64'd1);

      // Fixed path: ch2, three beats.
      do_reset();
      mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
      load(2, 27'h11, 1'b0); load(2, 27'h22, 1'b0); load(2, 27'h33, 1'b1);
      push_exp(2, 1'b0, 27'h11); push_exp(2, 1'b0, 27'h22); push_exp(2, 1'b1, 27'h33);
      present();
      drain("fix_drain");
      check("fix_latency", 64'(first_out - first_fire), 64'd1);
      check("fix_consec", 64'(last_out - first_out), 64'd2);

      // Round-robin over four single-beat producers.
      do_reset();
      mode = 1'b1;
      load(0, 27'h100, 1'b1); load(0, 27'h104, 1'b1);
      load(1, 27'h101, 1'b1); load(2, 27'h102, 1'b1); load(3, 27'h103, 1'b1);
      push_exp(0, 1'b1, 27'h100); push_exp(1, 1'b1, 27'h101); push_exp(2, 1'b1, 27'h102);
      push_exp(3, 1'b1, 27'h103); push_exp(0, 1'b1, 27'h104);
      present();
      drain("rr_drain");

      // After reset only ch3 valid.
      do_reset();
      mode = 1'b1;
      load(3, 27'h333, 1'b1);
      push_exp(3, 1'b1, 27'h333);
      present();
      drain("rr_ch3_drain");

      // Lock: ch1 4-beat packet, ch0 and select changes arrive mid-packet.
      do_reset();
      mode = 1'b1;
      load(1, 27'hA1, 1'b0); load(1, 27'hA2, 1'b0); load(1, 27'hA3, 1'b0); load(1, 27'hA4, 1'b1);
      load(0, 27'hB0, 1'b1);
      gap[0] = 1'b1;
      push_exp(1, 1'b0, 27'hA1); push_exp(1, 1'b0, 27'hA2); push_exp(1, 1'b0, 27'hA3);
      push_exp(1, 1'b1, 27'hA4); push_exp(0, 1'b1, 27'hB0);
      present();
      wait_head("lock_beat1", 1, 1);
      gap[0] = 1'b0; mode = 1'b0; sel = 2'd0; present();
      wait_head("lock_beat2", 1, 2);
      gap[1] = 1'b1; present(); #1;
      check("lock_bubble_rdy0", 64'(in_ready[0]), 64'd0);
      step(); step();
      check("lock_bubble_held", 64'(hd[1]), 64'd2);
      gap[1] = 1'b0; present();
      drain("lock_drain");

      // Backpressure: ch0 streams, out_ready low for 5 cycles.
      do_reset();
      mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         load(0, W'(27'hC0 + i), i == 9);
         push_exp(0, i == 9, W'(27'hC0 + i));
      end
      present();
      wait_head("bp_start", 0, 2);
      out_ready = 1'b0;
      h0 = hd[0];
      #1;
      check("bp_rdy_same_cycle", 64'(in_ready[0]), 64'(SKID));
      repeat (5) begin
         step();
         check("bp_hold_data", 64'(out_data), 64'(27'hC0 + h0 - 1));
         check("bp_hold_valid", 64'(out_valid), 64'd1);
      end
      check("bp_extra_beats", 64'(hd[0] - h0), 64'(SKID));
      out_ready = 1'b1;
      drain("bp_drain");
      check("bp_all_sent", 64'(hd[0]), 64'd10);

      // Async reset mid-packet.
      do_reset();
      mode = 1'b0; sel = 2'd1; out_ready = 1'b1;
      load(1, 27'hD1, 1'b0); load(1, 27'hD2, 1'b0); load(1, 27'hD3, 1'b1);
      present();
      wait_head("rst_first_beat", 1, 1);
      rst_n = 1'b0; #1;
      check("rst_async_valid", 64'(out_valid), 64'd0);
      sel = 2'd2;
      load(2, 27'hE0, 1'b1);
      push_exp(2, 1'b1, 27'hE0);
      present();
      @(posedge clk); #1; rst_n = 1'b1; #1;
      check("rst_new_sel_ready", 64'(in_ready), 64'b0100);
      drain("rst_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
